// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared FSM states and write-size helpers for the core-to-SRAM8 bridge.
package riscv_mem_pkg;
  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;
  localparam logic [1:0] WS_BYTE = 2'b00;
  localparam logic [1:0] WS_HALF = 2'b01;
  localparam logic [1:0] WS_WORD = 2'b10;
  localparam logic [1:0] WS_RSVD = 2'b11;
  function automatic logic [2:0] ws_bytes(input logic [1:0] ws);
    case (ws)
      WS_BYTE: return 3'd1;
      WS_HALF: return 3'd2;
      WS_WORD: return 3'd4;
      WS_RSVD: return 3'd0;
      default: return 3'd0;
    endcase
  endfunction
endpackage

// File: rtl/core_sram8_bridge.sv
// core_sram8_bridge: turns each 32-bit core bus cycle into byte-serial accesses on an 8-bit registered-read SRAM.
// Define MEM_RDCACHE_EN to add a one-entry read cache that answers repeated reads without an SRAM cycle.
module core_sram8_bridge
  import riscv_mem_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clock,
  input  logic          rst,
  input  logic [31:0]   a,
  input  logic [31:0]   o,
  input  logic          w,
  input  logic [1:0]    ws,
  output logic [31:0]   i,
  output logic          ce,
  output logic [AW-1:0] sram_a,
  output logic [7:0]    sram_d,
  input  logic [7:0]    sram_q,
  output logic          sram_we
);
  state_t state, nxt;
  logic [2:0] cnt, n_lat, ws_n;
  logic [AW-1:0] a_lat;
  logic [31:0] o_lat;
  logic w_lat, cap, hit, last, unused_hi;
  logic [1:0] cap_k;
  assign unused_hi = ^a[31:AW];
  assign ws_n = w ? ws_bytes(ws) : 3'd4;
  assign last = cnt + 3'd1 == n_lat;
`ifdef MEM_RDCACHE_EN
  logic c_valid;
  logic [AW-1:0] c_tag;
  logic [31:0] c_word;
  assign hit = !w && c_valid && c_tag == a[AW-1:0];
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      c_valid <= 1'b0;
      c_tag <= '0;
      c_word <= '0;
    end else begin
      if (state == IDLE && w) c_valid <= 1'b0;
      if (state == WAIT) begin
        c_valid <= 1'b1;
        c_tag <= a_lat;
        c_word <= {sram_q, i[23:0]};
      end
    end
  end
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? ((hit || ws_n == 3'd0) ? DONE : XFER)
        : state == XFER ? (last ? (w_lat ? DONE : WAIT) : XFER)
        : state == WAIT ? DONE : IDLE;
    ce = state == DONE;
    sram_we = state == XFER && w_lat;
    sram_a = state == XFER ? a_lat + AW'(cnt) : '0;
    sram_d = sram_we ? o_lat[{cnt[1:0], 3'b000} +: 8] : '0;
  end
  // Read data arrives one clock after its address, so capture runs one step behind cnt.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      n_lat <= '0;
      a_lat <= '0;
      o_lat <= '0;
      w_lat <= 1'b0;
      cap <= 1'b0;
      cap_k <= '0;
      i <= '0;
    end else begin
      cap <= state == XFER && !w_lat;
      cap_k <= cnt[1:0];
      if (state == IDLE) begin
        a_lat <= a[AW-1:0];
        o_lat <= o;
        w_lat <= w;
        n_lat <= ws_n;
        cnt <= '0;
      end
      if (state == XFER) cnt <= cnt + 3'd1;
      if (cap) i[{cap_k, 3'b000} +: 8] <= sram_q;
`ifdef MEM_RDCACHE_EN
      if (state == IDLE && hit) i <= c_word;
`endif
    end
  end
endmodule

// File: tb/tb_core_sram8_bridge.sv
// tb_core_sram8_bridge: random and directed transactions against a byte-array reference model.
// Honors MEM_RDCACHE_EN to expect cache-hit latencies.
module tb_core_sram8_bridge;
  logic clock = 1'b0, rst = 1'b1;
  logic [31:0] a = '0, o = '0;
  logic w = 1'b0;
  logic [1:0] ws = '0;
  logic [31:0] i;
  logic ce, sram_we;
  logic [15:0] sram_a;
  logic [7:0] sram_d, sram_q;
  logic [7:0] mem [65536];
  logic [7:0] mem_ref [65536];
  int passed = 0, total = 0;
  logic [31:0] last_i = '0;
  bit cvalid = 0;
  logic [15:0] ctag = '0;

  always #5 clock = ~clock;

  core_sram8_bridge #(.AW(16)) dut (
    .clock(clock), .rst(rst), .a(a), .o(o), .w(w), .ws(ws), .i(i), .ce(ce),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q), .sram_we(sram_we)
  );

  always @(posedge clock) begin
    if (sram_we) mem[sram_a] <= sram_d;
    sram_q <= mem[sram_a];
  end

  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called at the negedge of a DONE cycle, or right after reset release.
  task run(input logic [31:0] t_a, input logic t_w, input logic [1:0] t_ws, input logic [31:0] t_o);
    int n, lat, widx, exp_lat;
    logic [31:0] exp_i;
    logic [15:0] base;
    base = t_a[15:0];
    n = t_w ? (t_ws == 2'd0 ? 1 : t_ws == 2'd1 ? 2 : t_ws == 2'd2 ? 4 : 0) : 4;
    exp_i = last_i;
    if (!t_w) for (int k = 0; k < 4; k++) exp_i[8*k +: 8] = mem_ref[16'(base + k)];
    exp_lat = t_w ? n + 2 : 7;
`ifdef MEM_RDCACHE_EN
    if (!t_w && cvalid && ctag == base) exp_lat = 2;
    if (t_w) cvalid = 0;
    else begin
      cvalid = 1;
      ctag = base;
    end
`endif
    a = t_a; w = t_w; ws = t_ws; o = t_o;
    lat = 0;
    widx = 0;
    do begin
      @(negedge clock);
      lat++;
      if (sram_we) begin
        check("we_allowed", {31'b0, t_w && widx < n}, 32'd1);
        check("wr_addr", {16'b0, sram_a}, {16'b0, 16'(base + widx)});
        check("wr_data", {24'b0, sram_d}, {24'b0, t_o[8*(widx & 3) +: 8]});
        widx++;
      end
      if (lat >= 2 && !ce) begin
        a = $urandom; o = $urandom; w = 1'($urandom); ws = 2'($urandom);
      end
    end while (!ce && lat < 20);
    check("latency", lat, exp_lat);
    check("rdata", i, exp_i);
    check("wr_count", widx, n * int'(t_w));
    if (t_w) for (int k = 0; k < n; k++) mem_ref[16'(base + k)] = t_o[8*k +: 8];
    last_i = exp_i;
  endtask

  task check_reset_state;
    check("rst_ce", {31'b0, ce}, 32'd0);
    check("rst_i", i, 32'd0);
    check("rst_we", {31'b0, sram_we}, 32'd0);
    check("rst_a", {16'b0, sram_a}, 32'd0);
    check("rst_d", {24'b0, sram_d}, 32'd0);
  endtask

  initial begin
    int nmis, hunt;
    for (int k = 0; k < 65536; k++) begin
      mem[k] = 8'(k);
      mem_ref[k] = 8'(k);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_state();
    @(posedge clock);
    #1 rst = 1'b0;
    run(32'h10, 1'b0, 2'd2, 32'h0);
    check("t1_word", i, 32'h13121110);
    run(32'h20, 1'b1, 2'd2, 32'hDEADBEEF);
    run(32'h20, 1'b0, 2'd0, 32'h0);
    check("t2_word", i, 32'hDEADBEEF);
    run(32'h31, 1'b1, 2'd0, 32'h000000AA);
    run(32'h33, 1'b1, 2'd1, 32'h000055CC);
    run(32'h30, 1'b0, 2'd0, 32'h0);
    check("t3_lo", i, 32'hCC32AA30);
    run(32'h34, 1'b0, 2'd0, 32'h0);
    check("t3_hi", i, 32'h37363555);
    run(32'hABCDFFFE, 1'b0, 2'd2, 32'h0);
    check("t4_wrap", i, 32'h0100FFFE);
    run(32'h60, 1'b1, 2'd3, 32'h12345678);
    run(32'h60, 1'b0, 2'd0, 32'h0);
    run(32'h40, 1'b0, 2'd0, 32'h0);
    run(32'h40, 1'b0, 2'd0, 32'h0);
    run(32'h41, 1'b1, 2'd0, 32'h0000007E);
    run(32'h40, 1'b0, 2'd0, 32'h0);
    check("t6_word", i, 32'h43427E40);
    run(32'h40, 1'b0, 2'd0, 32'h0);
    // Abort a word write by asserting reset while byte 2 is on the bus.
    a = 32'h50; w = 1'b1; ws = 2'd2; o = 32'h11223344;
    hunt = 0;
    do begin
      @(negedge clock);
      hunt++;
    end while (!(sram_we && sram_a == 16'h0052) && hunt < 10);
    check("t5_reached", {31'b0, sram_we && sram_a == 16'h0052}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_we_drop", {31'b0, sram_we}, 32'd0);
    check("t5_ce", {31'b0, ce}, 32'd0);
    mem_ref[16'h50] = 8'h44;
    mem_ref[16'h51] = 8'h33;
    cvalid = 0;
    last_i = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_state();
    @(posedge clock);
    #1 rst = 1'b0;
    run(32'h50, 1'b0, 2'd0, 32'h0);
    check("t5_word", i, 32'h53523344);
    for (int t = 0; t < 80; t++) begin
      logic [31:0] ra;
      ra = $urandom;
      ra[15:0] = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                              : 16'(16'h80 + $urandom_range(0, 15));
      run(ra, 1'($urandom_range(0, 1)), 2'($urandom), $urandom);
    end
    nmis = 0;
    for (int k = 0; k < 65536; k++) if (mem[k] !== mem_ref[k]) nmis++;
    check("mem_final", nmis, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
